// File: rtl/uart_tx_fifo.sv
// UART transmitter with an internal baud divider, configurable frame format
// and a small write FIFO so upstream logic can queue words for back-to-back frames.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int DEPTH        = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_BITS-1:0]     tx_data,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  output logic                     rs232_tx,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int                AW        = $clog2(DEPTH);
  localparam int                CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]     BAUD_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic              LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic [AW:0]       FULL_LVL  = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  logic [DATA_BITS-1:0] r_mem [DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [AW:0]          r_count;

  state_t               r_state;
  logic                 r_tx;
  logic [CW-1:0]        r_baud_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic [3:0]           r_bit_idx;
  logic                 r_stop_idx;

  state_t               w_next_state;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_empty;
  logic                 w_bit_done;
  logic                 w_tx_next;
  logic                 w_shift;
  logic                 w_stop_adv;
  logic [DATA_BITS-1:0] w_fifo_dout;

  assign w_push      = tx_valid && tx_ready;
  assign w_empty     = (r_count == '0);
  assign w_bit_done  = (r_baud_cnt == BAUD_MAX);
  assign w_fifo_dout = r_mem[r_rd_ptr];

  assign tx_ready   = (r_count != FULL_LVL);
  assign rs232_tx   = r_tx;
  assign busy       = (r_state != S_IDLE) || !w_empty;
  assign fifo_level = r_count;

  // NOTE: storage has no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_tx_next    = r_tx;
    w_shift      = 1'b0;
    w_stop_adv   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_next_state = S_START;
          w_tx_next    = 1'b0;
        end
      end
      S_START: begin
        if (w_bit_done) begin
          w_next_state = S_DATA;
          w_tx_next    = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_bit_done) begin
          w_shift = 1'b1;
          if (r_bit_idx == LAST_DATA) begin
            if (PARITY != 0) begin
              w_next_state = S_PAR;
              w_tx_next    = r_par;
            end else begin
              w_next_state = S_STOP;
              w_tx_next    = 1'b1;
            end
          end else begin
            w_tx_next = r_shift[1];
          end
        end
      end
      S_PAR: begin
        if (w_bit_done) begin
          w_next_state = S_STOP;
          w_tx_next    = 1'b1;
        end
      end
      S_STOP: begin
        if (w_bit_done) begin
          if (r_stop_idx == LAST_STOP) begin
            // Chain straight into the next start bit when more data is queued.
            if (!w_empty) begin
              w_pop        = 1'b1;
              w_next_state = S_START;
              w_tx_next    = 1'b0;
            end else begin
              w_next_state = S_IDLE;
              w_tx_next    = 1'b1;
            end
          end else begin
            w_stop_adv = 1'b1;
          end
        end
      end
      default: begin
        w_next_state = S_IDLE;
        w_tx_next    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx       <= 1'b1;
      r_baud_cnt <= '0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_bit_idx  <= '0;
      r_stop_idx <= 1'b0;
    end else begin
      r_tx <= w_tx_next;
      if (r_state == S_IDLE || w_bit_done) r_baud_cnt <= '0;
      else                                 r_baud_cnt <= r_baud_cnt + CW'(1);
      if (w_pop) begin
        r_shift    <= w_fifo_dout;
        r_par      <= (^w_fifo_dout) ^ (PARITY == 1);
        r_bit_idx  <= '0;
        r_stop_idx <= 1'b0;
      end else if (w_shift) begin
        r_shift   <= r_shift >> 1;
        r_bit_idx <= r_bit_idx + 4'd1;
      end else if (w_stop_adv) begin
        r_stop_idx <= ~r_stop_idx;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three instances (8N1, 7E2, 7O2) at 4 clocks per bit,
// a cycle-exact line monitor fed by a scoreboard queue, table vectors and corner sequences.
module tb_uart_tx_fifo;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  int         sel = 0;

  always #5 clk = ~clk;

  logic       valid_a, valid_e, valid_o;
  logic       ready_a, ready_e, ready_o;
  logic       txd_a, txd_e, txd_o;
  logic       busy_a, busy_e, busy_o;
  logic [2:0] level_a, level_e, level_o;

  assign valid_a = tx_valid && (sel == 0);
  assign valid_e = tx_valid && (sel == 1);
  assign valid_o = tx_valid && (sel == 2);

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .tx_data(tx_data[7:0]), .tx_valid(valid_a), .tx_ready(ready_a),
    .rs232_tx(txd_a), .busy(busy_a), .fifo_level(level_a));
  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .DEPTH(4)) dut_e (
    .clk(clk), .rst(rst), .tx_data(tx_data[6:0]), .tx_valid(valid_e), .tx_ready(ready_e),
    .rs232_tx(txd_e), .busy(busy_e), .fifo_level(level_e));
  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .DEPTH(4)) dut_o (
    .clk(clk), .rst(rst), .tx_data(tx_data[6:0]), .tx_valid(valid_o), .tx_ready(ready_o),
    .rs232_tx(txd_o), .busy(busy_o), .fifo_level(level_o));

  logic       s_tx, s_busy, s_ready;
  logic [2:0] s_level;
  always_comb begin
    s_tx = txd_a; s_busy = busy_a; s_ready = ready_a; s_level = level_a;
    case (sel)
      1: begin s_tx = txd_e; s_busy = busy_e; s_ready = ready_e; s_level = level_e; end
      2: begin s_tx = txd_o; s_busy = busy_o; s_ready = ready_o; s_level = level_o; end
      default: ;
    endcase
  end

  int db_tab  [3] = '{8, 7, 7};
  int par_tab [3] = '{0, 2, 1};
  int sb_tab  [3] = '{1, 2, 2};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: words pushed on acceptance, popped when the line shows a start bit.
  logic [8:0] sb_q[$];

  int   cyc = 0;
  bit   m_active = 1'b0;
  int   m_idx, m_n, m_par_pos;
  logic m_bits [16];
  logic m_par_seen = 1'b0;
  int   frames_done = 0;
  int   b2b_cnt = 0;
  int   last_end = -10;
  int   max_level = 0;

  function automatic void build_frame(input logic [8:0] d);
    int   idx;
    logic par;
    idx = 1;
    par = 1'b0;
    m_bits[0] = 1'b0;
    for (int i = 0; i < db_tab[sel]; i++) begin
      m_bits[idx] = d[i];
      par = par ^ d[i];
      idx++;
    end
    if (par_tab[sel] != 0) begin
      m_bits[idx] = (par_tab[sel] == 1) ? ~par : par;
      m_par_pos = idx;
      idx++;
    end else begin
      m_par_pos = -1;
    end
    for (int s = 0; s < sb_tab[sel]; s++) begin
      m_bits[idx] = 1'b1;
      idx++;
    end
    m_n = idx;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (int'(s_level) > max_level) max_level = int'(s_level);
      if (rst) begin
        m_active = 1'b0;
      end else if (!m_active) begin
        if (s_tx == 1'b0) begin
          check("frame_expected", 32'(sb_q.size() != 0), 32'd1);
          build_frame((sb_q.size() != 0) ? sb_q.pop_front() : 9'h000);
          if (last_end == cyc - 1) b2b_cnt++;
          m_active = 1'b1;
          m_idx    = 1;
        end
      end else begin
        check($sformatf("line_bit%0d", m_idx / CPB), 32'(s_tx), 32'(m_bits[m_idx / CPB]));
        if (m_idx / CPB == m_par_pos && m_idx % CPB == 0) m_par_seen = s_tx;
        m_idx++;
        if (m_idx == m_n * CPB) begin
          m_active = 1'b0;
          last_end = cyc;
          frames_done++;
        end
      end
    end
  end

  bit saw_not_ready = 1'b0;

  task automatic push(input logic [8:0] d);
    int guard;
    guard = 0;
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    while (!s_ready && guard < 200) begin
      saw_not_ready = 1'b1;
      @(negedge clk);
      guard++;
    end
    check("push_ready", 32'(s_ready), 32'd1);
    @(posedge clk);
    sb_q.push_back(d);
    #1 tx_valid = 1'b0;
  endtask

  task automatic wait_frames(input int target, input string name);
    int g;
    g = 0;
    while (frames_done < target && g < 2000) begin
      @(negedge clk);
      g++;
    end
    check(name, frames_done, target);
  endtask

  task automatic wait_idle(input string name);
    int g;
    g = 0;
    while (s_busy && g < 200) begin
      @(negedge clk);
      g++;
    end
    check(name, 32'(s_busy), 32'd0);
  endtask

  typedef struct {
    int         sel;
    logic [8:0] data;
    bit         has_par;
    logic       exp_par;
    int         exp_len;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd0, b0, cnt, guard, low_cnt;
    bit first;
    logic [8:0] burst [6];

    vecs[0] = '{0, 9'h0A5, 1'b0, 1'b0, 40};
    vecs[1] = '{0, 9'h000, 1'b0, 1'b0, 40};
    vecs[2] = '{0, 9'h0FF, 1'b0, 1'b0, 40};
    vecs[3] = '{1, 9'h055, 1'b1, 1'b0, 44};
    vecs[4] = '{1, 9'h07F, 1'b1, 1'b1, 44};
    vecs[5] = '{2, 9'h055, 1'b1, 1'b1, 44};
    vecs[6] = '{2, 9'h001, 1'b1, 1'b0, 44};
    vecs[7] = '{2, 9'h03C, 1'b1, 1'b1, 44};
    burst   = '{9'h011, 9'h022, 9'h033, 9'h044, 9'h055, 9'h066};

    repeat (3) @(negedge clk);
    check("rst_tx",    32'(txd_a),   32'd1);
    check("rst_ready", 32'(ready_a), 32'd1);
    check("rst_busy",  32'(busy_a),  32'd0);
    check("rst_level", 32'(level_a), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 8; v++) begin
      sel = vecs[v].sel;
      fd0 = frames_done;
      push(vecs[v].data);
      @(negedge clk);
      check("accept_cycle_tx",    32'(s_tx),    32'd1);
      check("accept_cycle_level", 32'(s_level), 32'd1);
      cnt = 0; guard = 0; first = 1'b1;
      while (guard < 200) begin
        @(negedge clk);
        guard++;
        if (first) begin
          check("start_latency", 32'(s_tx), 32'd0);
          first = 1'b0;
        end
        if (!s_busy) break;
        if (s_level == 3'd0) cnt++;
      end
      check("frame_len",  cnt, vecs[v].exp_len);
      check("idle_tx",    32'(s_tx), 32'd1);
      check("idle_busy",  32'(s_busy), 32'd0);
      check("frame_seen", frames_done, fd0 + 1);
      if (vecs[v].has_par) check("parity_bit", 32'(m_par_seen), 32'(vecs[v].exp_par));
    end

    // Async reset while idle, sampled before any clock edge.
    sel = 0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("idle_rst_tx",    32'(txd_a),   32'd1);
    check("idle_rst_ready", 32'(ready_a), 32'd1);
    check("idle_rst_busy",  32'(busy_a),  32'd0);
    check("idle_rst_level", 32'(level_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Burst of six with a four-deep FIFO.
    saw_not_ready = 1'b0;
    max_level = 0;
    fd0 = frames_done;
    b0  = b2b_cnt;
    for (int i = 0; i < 6; i++) push(burst[i]);
    wait_frames(fd0 + 6, "burst_frames");
    wait_idle("burst_idle");
    check("burst_b2b",       b2b_cnt - b0, 5);
    check("burst_not_ready", 32'(saw_not_ready), 32'd1);
    check("burst_max_level", max_level, 4);
    check("burst_sb_empty",  sb_q.size(), 0);

    // Reset during data bit 3 of 0xA5 (bit3 = 0) with two words queued.
    push(9'h0A5);
    push(9'h05A);
    push(9'h069);
    repeat (17) @(negedge clk);
    check("pre_rst_level", 32'(level_a), 32'd2);
    check("pre_rst_tx",    32'(txd_a),   32'd0);
    rst = 1'b1;
    #1;
    check("mid_rst_tx",    32'(txd_a),   32'd1);
    check("mid_rst_level", 32'(level_a), 32'd0);
    check("mid_rst_busy",  32'(busy_a),  32'd0);
    check("mid_rst_ready", 32'(ready_a), 32'd1);
    repeat (2) @(negedge clk);
    sb_q.delete();
    rst = 1'b0;
    fd0 = frames_done;
    low_cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (!txd_a || busy_a) low_cnt++;
    end
    check("post_rst_quiet",  low_cnt, 0);
    check("post_rst_frames", frames_done, fd0);

    // Push on the same edge as the stop-end pop, with one word queued.
    fd0 = frames_done;
    b0  = b2b_cnt;
    push(9'h081);
    push(9'h042);
    repeat (39) @(posedge clk);
    #1;
    check("swap_level_before", 32'(level_a), 32'd1);
    push(9'h099);
    check("swap_level_after", 32'(level_a), 32'd1);
    check("swap_ready_after", 32'(ready_a), 32'd1);
    check("swap_start_bit",   32'(txd_a),   32'd0);
    wait_frames(fd0 + 3, "swap_frames");
    wait_idle("swap_idle");
    check("swap_b2b",      b2b_cnt - b0, 2);
    check("final_sb_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter, the successor to the fixed 8N1 transmitter. It has an internal baud divider, so no external clk_bps/bps_start pair is needed. Data width, parity mode and stop-bit count are set by parameters, and a small FIFO with a valid/ready write handshake lets upstream logic queue several words. Frames go out back-to-back on rs232_tx with no idle gap while the FIFO holds data.

Parameters:
CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200); legal range 2..65535
DATA_BITS, 8, payload bits per frame; legal 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits per frame; legal 1 or 2
DEPTH, 4, FIFO entries; power of two, >= 2

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-high
tx_data  input  DATA_BITS  word to transmit, LSB sent first
tx_valid  input  1  tx_data valid this cycle
tx_ready  output  1  FIFO can accept a word (= not full)
rs232_tx  output  1  serial line, idle high
busy  output  1  high while any frame is in progress or the FIFO is non-empty
fifo_level  output  clog2(DEPTH)+1  number of words queued, not counting the frame in flight

Behaviour:
- Reset (rst high, async): rs232_tx=1, tx_ready=1, busy=0, fifo_level=0. FSM=IDLE, baud counter=0, FIFO pointers cleared. Reset mid-frame aborts the frame immediately; the line returns high at once and all queued words are discarded.
- Write handshake: a word is accepted on a rising edge where tx_valid && tx_ready. tx_ready = (fifo_level != DEPTH), combinational from registered state. tx_valid while not ready is ignored; upstream must hold the data.
- FIFO: circular buffer with wrapping read and write pointers and a count register. A push and a pop on the same edge leave fifo_level unchanged. A pop occurs only when non-empty. A push occurs only when not full.
- FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: rs232_tx=1. If the FIFO is non-empty, pop into the shift register, compute the parity bit, enter START, and drive rs232_tx=0 on the same edge.
  - Word accepted at edge k into an empty FIFO while IDLE -> rs232_tx low from edge k+1.
  - Baud counter runs 0..CLKS_PER_BIT-1 within each bit. Every bit, including start, parity and stop, holds exactly CLKS_PER_BIT cycles.
  - START -> DATA after one bit time. DATA shifts out DATA_BITS bits LSB first.
  - DATA -> PAR if PARITY != 0, else DATA -> STOP.
  - Parity bit: even mode = XOR of the data bits; odd mode = its inverse.
  - STOP drives 1 for STOP_BITS bit times.
  - At the end of STOP: if the FIFO is non-empty, pop and go directly to START, driving 0 on that edge with no idle cycle. Otherwise go to IDLE.
- Frame length = (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * CLKS_PER_BIT cycles.
- A push on the same edge the FSM pops from an empty-becoming... queue: a push into an empty FIFO is visible to the FSM on the next edge, never the same edge.
- busy = (state != IDLE) || (fifo_level != 0).
- All outputs are registered or derived only from registered state. No combinational path runs from tx_valid/tx_data to any output.

Test Plan:
- Reset defaults: assert rst mid-idle -> rs232_tx=1, tx_ready=1, busy=0, fifo_level=0 without any clk edge.
- 8N1, CLKS_PER_BIT=4, send 0xA5 -> rs232_tx low 1 cycle after accept. Then 1,0,1,0,0,1,0,1, each for 4 cycles, then high. Frame totals 40 cycles and busy drops immediately after.
- PARITY=2, STOP_BITS=2, DATA_BITS=7, send 0x55 -> parity bit 0 after bit6. Two stop bit times (8 cycles at CLKS_PER_BIT=4). Frame totals 44 cycles. Repeat with PARITY=1 -> parity bit 1.
- Burst of 6 words with DEPTH=4 and tx_valid held -> tx_ready low after the FIFO fills (4 queued plus 1 in flight). fifo_level never exceeds 4. All 6 frames go out back-to-back with no idle cycle between stop and start, and data order is preserved.
- Reset mid-frame: assert rst during bit 3 with 2 words queued -> rs232_tx high immediately and fifo_level=0. After release, no further frames are sent until a new word is written.
- Simultaneous push/pop: FIFO at level 1, write on the edge the FSM pops at stop end -> fifo_level stays 1 and tx_ready stays 1.
